// File: rtl/uart_fifo_pkg.sv
// Shared definitions for the UART serial FIFO blocks: frame geometry,
// receive state encoding and default FIFO geometry.
package uart_fifo_pkg;

    localparam int unsigned FRAME_LEN        = 11;
    localparam int unsigned DATA_BITS        = 8;
    localparam int unsigned FIFO_DEPTH_DEF   = 16;
    localparam int unsigned FIFO_WIDTH_DEF   = DATA_BITS + 1;

    typedef enum logic [1:0] {
        RX_IDLE    = 2'd0,
        RX_DATA    = 2'd1,
        RX_STOP    = 2'd2,
        RX_RECOVER = 2'd3
    } rx_state_t;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/rx_fifo_mem.sv
// Circular buffer with registered read port, wrapping pointers and an
// occupancy count; a write into a full buffer succeeds only alongside a pop.
module rx_fifo_mem
    import uart_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_WIDTH_DEF,
    parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             full_next,
    output logic             wr_drop
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             pop;
    logic             wr_ok;

    always_comb begin
        pop        = rd_en && !empty;
        wr_ok      = wr_en && ((count < FULL_CNT) || pop);
        wr_drop    = wr_en && !wr_ok;
        count_next = count;
        unique case ({wr_ok, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
        full_next  = (count_next == FULL_CNT);
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
            empty   <= 1'b1;
            full    <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            count <= count_next;
            empty <= (count_next == '0);
            full  <= full_next;
        end
    end

endmodule

// File: rtl/rx_serial_fifo.sv
// Serial receive FIFO: deserialises start/8 data/parity/stop frames into rx_fifo_mem.
// Define RX_PARITY_CHECK_EN to reject frames failing even parity (pulses parity_err).
module rx_serial_fifo
    import uart_fifo_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH_R = FIFO_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH_R = FIFO_DEPTH_DEF
) (
    input  logic                 baud_clk,
    input  logic                 rst,
    input  logic                 data_in,
    input  logic                 read_en,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 parity_out,
    output logic                 Rx_ready,
    output logic                 RxFF,
    output logic                 RxFE,
    output logic                 overrun,
    output logic                 framing_err,
    output logic                 parity_err
);

    localparam int unsigned CNT_W = $clog2(FRAME_LEN);

    rx_state_t             state;
    rx_state_t             state_nxt;
    logic [CNT_W-1:0]      bit_cnt;
    logic [FIFO_WIDTH_R-1:0] shreg;
    logic [FIFO_WIDTH_R-1:0] rd_word;
    logic                  commit;
    logic                  frame_bad;
    logic                  par_bad;
    logic                  full_next;
    logic                  wr_drop;

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        frame_bad = 1'b0;
        par_bad   = 1'b0;
        unique case (state)
            RX_IDLE: begin
                if (!data_in) state_nxt = RX_DATA;
            end
            RX_DATA: begin
                if (bit_cnt == CNT_W'(DATA_BITS)) state_nxt = RX_STOP;
            end
            RX_STOP: begin
                if (data_in) begin
                    state_nxt = RX_IDLE;
`ifdef RX_PARITY_CHECK_EN
                    if (shreg[DATA_BITS] == even_parity(shreg[DATA_BITS-1:0])) begin
                        commit = 1'b1;
                    end else begin
                        par_bad = 1'b1;
                    end
`else
                    commit = 1'b1;
`endif
                end else begin
                    frame_bad = 1'b1;
                    state_nxt = RX_RECOVER;
                end
            end
            RX_RECOVER: begin
                if (data_in) state_nxt = RX_IDLE;
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    // Rx_ready looks at next state and next occupancy so it drops the cycle
    // after start detection and recovers in the cycle following commit.
    always_ff @(posedge baud_clk) begin
        if (rst) begin
            state       <= RX_IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            Rx_ready    <= 1'b1;
            overrun     <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            Rx_ready    <= (state_nxt == RX_IDLE) && !full_next;
            overrun     <= wr_drop;
            framing_err <= frame_bad;
            if (state == RX_IDLE) begin
                bit_cnt <= '0;
            end else if (state == RX_DATA) begin
                shreg[bit_cnt] <= data_in;
                bit_cnt        <= bit_cnt + 1'b1;
            end
        end
    end

`ifdef RX_PARITY_CHECK_EN
    always_ff @(posedge baud_clk) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= par_bad;
        end
    end
`else
    assign parity_err = 1'b0;
    logic unused_par_bad;
    assign unused_par_bad = par_bad;
`endif

    rx_fifo_mem #(
        .WIDTH (FIFO_WIDTH_R),
        .DEPTH (FIFO_DEPTH_R)
    ) u_mem (
        .clk       (baud_clk),
        .rst       (rst),
        .wr_en     (commit),
        .wr_data   (shreg),
        .rd_en     (read_en),
        .rd_data   (rd_word),
        .full      (RxFF),
        .empty     (RxFE),
        .full_next (full_next),
        .wr_drop   (wr_drop)
    );

    assign {parity_out, data_out} = rd_word[DATA_BITS:0];

endmodule

// File: doc/rx_serial_fifo.md
# rx_serial_fifo

Serial-in / parallel-out receive FIFO: the far end of the transmit FIFO's serial link. Deserialises 11-bit frames (start 0, d0..d7 LSB first, parity, stop 1) sampled once per `baud_clk`, stores `{parity, data}` words in a circular buffer, and presents them to the consumer through a read-enable port. It drives `Rx_ready` back to the transmitter so that a new frame is launched only when the receiver can accept it.

## Interface
- `FIFO_WIDTH_R`, 9, stored word width: parity bit plus 8 data bits.
- `FIFO_DEPTH_R`, 16, number of entries; must be a power of two.
- `baud_clk`  in  1  bit clock, shared with the transmitter; one serial bit per cycle.
- `rst`  in  1  synchronous, active-high reset.
- `data_in`  in  1  serial line; idles high.
- `read_en`  in  1  consumer pop request.
- `data_out`  out  8  popped data byte.
- `parity_out`  out  1  popped parity bit.
- `Rx_ready`  out  1  receiver idle with at least one free entry.
- `RxFF`  out  1  FIFO full.
- `RxFE`  out  1  FIFO empty.
- `overrun`  out  1  1-cycle pulse: valid frame dropped because the FIFO was full.
- `framing_err`  out  1  1-cycle pulse: stop bit sampled low.
- `parity_err`  out  1  1-cycle pulse: parity mismatch (only with macro, else tied 0).

## Operation
- Receive FSM: IDLE, DATA, STOP, RECOVER.
  - IDLE: `data_in`==0 goes to DATA, with `bit_cnt`=0.
  - DATA: shift `data_in` into `shreg[bit_cnt]` and increment. After `bit_cnt`==8 (the parity bit) go to STOP.
  - STOP, `data_in`==1: commit the frame, then go to IDLE.
  - STOP, `data_in`==0: pulse `framing_err`, discard the frame, go to RECOVER.
  - RECOVER: stay until `data_in`==1, then go to IDLE. A low line is never treated as a new start bit in this state.
- Commit: write `shreg` to `mem[wr_ptr]` and increment `wr_ptr` when `count` < DEPTH, or when `count` == DEPTH and a pop occurs in the same cycle. Otherwise pulse `overrun` and leave memory and pointers unchanged.
- Pop: on `read_en && !RxFE`, register `{parity_out, data_out}` from `mem[rd_ptr]` and increment `rd_ptr`. A pop while empty is ignored and the outputs hold.
- `count` is log2(DEPTH)+1 bits wide:
  - commit only: +1; pop only: −1; commit and pop together: unchanged.
  - `RxFF` = (`count` == DEPTH); `RxFE` = (`count` == 0). Both are registered.
- Pointers are log2(DEPTH) bits wide and wrap naturally from DEPTH−1 to 0.
- `Rx_ready` (registered) = next state is IDLE and next `count` < DEPTH.
- Reset values: state IDLE, pointers 0, `count` 0, `data_out` 0, `parity_out` 0, `RxFE` 1, `RxFF` 0, `Rx_ready` 1, all error pulses 0. Reset mid-frame discards the partial frame.

## Timing
- Start bit sampled in cycle 0; d0..d7 in cycles 1–8; parity in cycle 9; stop in cycle 10.
- Commit occurs at the end of cycle 10. `RxFE` falls and `count` increments from cycle 11.
- `Rx_ready` drops in cycle 1, the cycle after start detection. It returns high in cycle 11 if space remains.
- Pop latency is 1 cycle: with `read_en` in cycle n, `data_out` is valid in cycle n+1.
- Error pulses are asserted in cycle 11, for exactly one cycle.
- Back-to-back frames are legal: a start bit in cycle 11 is accepted.

## Configuration
- `RX_PARITY_CHECK_EN` defined:
  - At STOP with a good stop bit, check even parity: expected parity bit = ^d[7:0].
  - On mismatch: pulse `parity_err`, do not write the frame, do not pulse `overrun`.
  - On a match: store the frame normally.
- Undefined: no check is made; the received parity bit is stored raw and returned on `parity_out`; `parity_err` is tied 0.

## Structure
- Shared package `uart_fifo_pkg`:
  - frame length constant (11) and data bit count (8);
  - receive state encoding (IDLE=0, DATA=1, STOP=2, RECOVER=3);
  - default depth and width.
- One sub-module, `rx_fifo_mem`: the storage array with pointer and count logic, shared with future FIFO blocks. The deserialiser FSM lives in `rx_serial_fifo`.

## Test plan
- Frame 0xA5 with parity 0 (correct even parity) → cycle 11: `RxFE`=0. `read_en` in cycle 12 → cycle 13: `data_out`=0xA5, `parity_out`=0, `RxFE`=1.
- 16 back-to-back frames 0x00..0x0F with no reads → `RxFF`=1, `Rx_ready`=0. Frame 17 (0xFF) → `overrun` pulse; 16 pops return 0x00..0x0F in order.
- Stop bit driven 0, then line held low 5 cycles, then high → `framing_err` pulse, no commit, no spurious start. Next valid frame 0x3C is received correctly.
- Frame 0x07 with parity 0:
  - with `RX_PARITY_CHECK_EN` → `parity_err` pulse, `RxFE` stays 1;
  - without the macro → stored, pop gives `data_out`=0x07, `parity_out`=0.
- Wrap-around: 40 frames with a pop after every frame → data order preserved across both pointer wraps; `RxFF` never asserts.
- `rst` asserted in cycle 5 of a frame, then released → all outputs at their reset values. Frame 0x81 sent next → received intact.
